// File: rtl/disp_pkg.sv
// Shared constants, view encodings and hex-to-segment table for the debug display scanner.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    MODE_REG_LO  = 2'b00,
    MODE_REG_HI  = 2'b01,
    MODE_STEP_PC = 2'b10,
    MODE_PC      = 2'b11
  } mode_e;

  // Active-low gfedcba, entry 15 (F) leftmost down to entry 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [15:0] select_view(mode_e       mode,
                                              logic [31:0] reg_value,
                                              logic [8:0]  pc,
                                              logic [7:0]  step_count);
    logic [15:0] view;
    case (mode)
      MODE_REG_LO:  view = reg_value[15:0];
      MODE_REG_HI:  view = reg_value[31:16];
      MODE_STEP_PC: view = {step_count, pc[7:0]};
      default:      view = {7'b0, pc};
    endcase
    return view;
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Debug-value inputs and display outputs of the seven-segment scanner.
interface disp_scan_if;
  logic [1:0]  mode;
  logic [31:0] reg_value;
  logic [8:0]  pc;
  logic [7:0]  step_count;
  logic [3:0]  disp_anode;
  logic [7:0]  disp_seg;

  modport master (
    output mode, reg_value, pc, step_count,
    input  disp_anode, disp_seg
  );

  modport slave (
    input  mode, reg_value, pc, step_count,
    output disp_anode, disp_seg
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba decoder with blanking.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
    if (blank) seg = 7'h7F;
  end

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed seven-segment driver; latches one coherent 16-bit view per scan frame.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic      clock,
  input  logic      reset,
  disp_scan_if.slave bus
);

  logic [SCAN_DIV-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [15:0]         frame_q, frame_d;
  mode_e               frame_mode_q, frame_mode_d;
  logic                load_pend_q;
  logic [3:0]          anode_q, anode_d;
  logic [7:0]          seg_q, seg_d;

  logic       tick;
  logic       load;
  logic [3:0] nibble;
  logic       blank;
  logic       dp;
  logic [6:0] seg7;

  always_comb begin
    tick         = &div_cnt_q;
    div_cnt_d    = div_cnt_q + SCAN_DIV'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    // Reload only at the frame boundary so every frame shows one coherent snapshot.
    load         = load_pend_q || (tick && (idx_q == 2'd3));
    frame_d      = frame_q;
    frame_mode_d = frame_mode_q;
    if (load) begin
      frame_mode_d = mode_e'(bus.mode);
      frame_d      = select_view(mode_e'(bus.mode), bus.reg_value, bus.pc, bus.step_count);
    end
  end

  always_comb begin
    nibble = frame_q[{idx_q, 2'b00} +: 4];
    blank  = 1'b0;
    if (BLANK_LZ) begin
      unique case (idx_q)
        2'd3:    blank = (frame_q[15:12] == 4'h0);
        2'd2:    blank = (frame_q[15:8] == 8'h00);
        2'd1:    blank = (frame_q[15:4] == 12'h000);
        default: blank = 1'b0;
      endcase
    end
    dp = (idx_q == 2'd3) && ((frame_mode_q == MODE_REG_HI) || (frame_mode_q == MODE_PC));
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg7)
  );

  always_comb begin
    anode_d = ~(4'b0001 << idx_q);
    seg_d   = {~dp, seg7};
    // Outputs stay dark until the first frame has been captured.
    if (load_pend_q) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_BLANK;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      idx_q        <= 2'd0;
      frame_q      <= 16'h0000;
      frame_mode_q <= MODE_REG_LO;
      load_pend_q  <= 1'b1;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_BLANK;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      frame_mode_q <= frame_mode_d;
      load_pend_q  <= 1'b0;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.disp_anode = anode_q;
  assign bus.disp_seg   = seg_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: two instances (plain and leading-zero blanking), SCAN_DIV=2.
module tb_disp_scan;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   edge_n = 0;

  disp_scan_if bus0 ();
  disp_scan_if bus1 ();

  disp_scan #(.SCAN_DIV(2), .BLANK_LZ(1'b0)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  disp_scan #(.SCAN_DIV(2), .BLANK_LZ(1'b1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle to the falling edge for sampling and driving.
  task automatic step();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  // Advance until the output shows digit 0 of a frame loaded after the current inputs.
  task automatic go_frame_start();
    do step(); while (edge_n % 16 != 0);
    step();
  endtask

  task automatic test_reset();
    bus0.mode = 2'b00; bus0.reg_value = 32'h1234ABCD; bus0.pc = 9'h000; bus0.step_count = 8'h00;
    bus1.mode = 2'b10; bus1.reg_value = 32'h0;        bus1.pc = 9'h005; bus1.step_count = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (bus0.disp_anode !== 4'b1111 || bus0.disp_seg !== 8'hFF)
      $display("FAIL reset_held: anode=%b seg=%h expected 1111/ff", bus0.disp_anode, bus0.disp_seg);
    else passed++;
    reset = 1'b0; edge_n = 0;
    repeat (9) step();
    total++;
    if (bus0.disp_anode !== 4'b1011 || bus0.disp_seg !== 8'h83)
      $display("FAIL pre_reset_digit2: anode=%b seg=%h expected 1011/83",
               bus0.disp_anode, bus0.disp_seg);
    else passed++;
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus0.disp_anode !== 4'b1111 || bus0.disp_seg !== 8'hFF)
      $display("FAIL reset_async: anode=%b seg=%h expected 1111/ff", bus0.disp_anode, bus0.disp_seg);
    else passed++;
    @(negedge clock);
    reset = 1'b0; edge_n = 0;
    step();
    total++;
    if (bus0.disp_anode !== 4'b1111 || bus0.disp_seg !== 8'hFF)
      $display("FAIL first_cycle_dark: anode=%b seg=%h expected 1111/ff",
               bus0.disp_anode, bus0.disp_seg);
    else passed++;
    step();
    total++;
    if (bus0.disp_anode !== 4'b1110 || bus0.disp_seg !== 8'hA1)
      $display("FAIL first_lit: anode=%b seg=%h expected 1110/a1", bus0.disp_anode, bus0.disp_seg);
    else passed++;
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    logic [3:0] exp_an;
    int d;
    for (int i = 0; i < 32; i++) begin
      step();
      d = ((edge_n - 1) / 4) % 4;
      exp_an = 4'b1111 ^ (4'b0001 << d);
      total++;
      if (bus0.disp_anode !== exp_an || bus0.disp_seg !== exp_seg[d])
        $display("FAIL scan edge %0d: anode=%b seg=%h expected %b/%h",
                 edge_n, bus0.disp_anode, bus0.disp_seg, exp_an, exp_seg[d]);
      else passed++;
    end
  endtask

  task automatic test_coherence();
    logic [7:0] old_seg [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    logic [7:0] exp;
    logic [3:0] exp_an;
    int boundary;
    int d;
    do step(); while (edge_n % 16 != 5);
    bus0.reg_value = 32'h0000_0000;
    boundary = edge_n + 11;
    for (int i = 0; i < 27; i++) begin
      step();
      d = ((edge_n - 1) / 4) % 4;
      exp = (edge_n - 1 >= boundary) ? 8'hC0 : old_seg[d];
      exp_an = 4'b1111 ^ (4'b0001 << d);
      total++;
      if (bus0.disp_anode !== exp_an || bus0.disp_seg !== exp)
        $display("FAIL coherence edge %0d: anode=%b seg=%h expected %b/%h",
                 edge_n, bus0.disp_anode, bus0.disp_seg, exp_an, exp);
      else passed++;
    end
  endtask

  task automatic test_views();
    logic [7:0] exp_pc [4] = '{8'h8E, 8'h8E, 8'hF9, 8'h40};
    logic [7:0] exp_hi [4] = '{8'hC0, 8'hC0, 8'hC0, 8'h00};
    bus0.mode = 2'b11; bus0.pc = 9'h1FF;
    go_frame_start();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus0.disp_anode !== (4'b1111 ^ (4'b0001 << (i / 4))) || bus0.disp_seg !== exp_pc[i / 4])
        $display("FAIL view_pc digit %0d: anode=%b seg=%h expected seg %h",
                 i / 4, bus0.disp_anode, bus0.disp_seg, exp_pc[i / 4]);
      else passed++;
      step();
    end
    bus0.mode = 2'b01; bus0.reg_value = 32'h8000_0000;
    go_frame_start();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus0.disp_seg !== exp_hi[i / 4])
        $display("FAIL view_reg_hi digit %0d: seg=%h expected %h",
                 i / 4, bus0.disp_seg, exp_hi[i / 4]);
      else passed++;
      step();
    end
  endtask

  task automatic test_blank();
    logic [7:0] exp_a [4] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_b [4] = '{8'h92, 8'hC0, 8'hC0, 8'hF9};
    logic [7:0] exp_c [4] = '{8'h92, 8'hFF, 8'hFF, 8'h7F};
    bus1.mode = 2'b10; bus1.step_count = 8'h00; bus1.pc = 9'h005;
    go_frame_start();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus1.disp_anode !== (4'b1111 ^ (4'b0001 << (i / 4))) || bus1.disp_seg !== exp_a[i / 4])
        $display("FAIL blank_lz digit %0d: anode=%b seg=%h expected seg %h",
                 i / 4, bus1.disp_anode, bus1.disp_seg, exp_a[i / 4]);
      else passed++;
      step();
    end
    bus1.step_count = 8'h10;
    go_frame_start();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus1.disp_seg !== exp_b[i / 4])
        $display("FAIL blank_inner_zero digit %0d: seg=%h expected %h",
                 i / 4, bus1.disp_seg, exp_b[i / 4]);
      else passed++;
      step();
    end
    bus1.mode = 2'b11;
    go_frame_start();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus1.disp_seg !== exp_c[i / 4])
        $display("FAIL blank_with_dp digit %0d: seg=%h expected %h",
                 i / 4, bus1.disp_seg, exp_c[i / 4]);
      else passed++;
      step();
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] exp_pc [4] = '{8'h8E, 8'h8E, 8'hF9, 8'h40};
    bus0.mode = 2'b00; bus0.reg_value = 32'h1234ABCD; bus0.pc = 9'h1FF;
    go_frame_start();
    do step(); while (edge_n % 16 != 15);
    bus0.mode = 2'b11;
    step();
    total++;
    if (bus0.disp_anode !== 4'b0111 || bus0.disp_seg !== 8'h88)
      $display("FAIL switch_old_digit3: anode=%b seg=%h expected 0111/88",
               bus0.disp_anode, bus0.disp_seg);
    else passed++;
    step();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus0.disp_anode !== (4'b1111 ^ (4'b0001 << (i / 4))) || bus0.disp_seg !== exp_pc[i / 4])
        $display("FAIL switch_new_frame digit %0d: anode=%b seg=%h expected seg %h",
                 i / 4, bus0.disp_anode, bus0.disp_seg, exp_pc[i / 4]);
      else passed++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherence();
    test_views();
    test_blank();
    test_mode_switch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
